// File: rtl/hdmi_clk_pkg.sv
// Shared types and 50 MHz default timing constants for the HDMI PLL supervisor.
package hdmi_clk_pkg;

  // Supervisor sequencing states.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } sup_state_t;

  // Registered control outputs toward the rPLL and the pixel reset tree.
  typedef struct packed {
    logic pll_reset;
    logic pix_rst;
    logic locked_ok;
    logic fail;
  } sup_ctl_t;

  // Defaults for a 50 MHz reference clock.
  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 5000;
  localparam int unsigned DEF_MAX_RETRY     = 3;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned LOSS_W            = 8;

  // Control outputs implied by being in a given state.
  function automatic sup_ctl_t ctl_for_state(input sup_state_t st);
    sup_ctl_t c;
    c.pll_reset = (st == PLL_RST) || (st == FAIL);
    c.pix_rst   = (st != RUN);
    c.locked_ok = (st == RUN);
    c.fail      = (st == FAIL);
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status bits; resets to 0.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hdmi_pll_supervisor.sv
// Sequences the HDMI rPLL reset, qualifies LOCK, and gates the pixel-domain reset.
module hdmi_pll_supervisor
  import hdmi_clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                               i_clkin,
  input  logic                               i_reset,
  input  logic                               i_pll_lock,
  input  logic                               i_restart,
  output logic                               o_pll_reset,
  output logic                               o_pix_rst,
  output logic                               o_locked_ok,
  output logic                               o_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]     o_retry_cnt,
  output logic [LOSS_W-1:0]                  o_loss_cnt
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);
  localparam logic [LOSS_W-1:0] LOSS_SAT   = '1;

  sup_state_t        r_state;
  sup_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_timer;
  logic [CNT_W-1:0]  w_timer_nxt;
  logic [RW-1:0]     r_retry_cnt;
  logic [RW-1:0]     w_retry_nxt;
  logic [LOSS_W-1:0] r_loss_cnt;
  logic [LOSS_W-1:0] w_loss_nxt;
  sup_ctl_t          r_ctl;
  sup_ctl_t          w_ctl_nxt;
  logic [0:0]        w_lock_s;

  // Bring the asynchronous LOCK into the clkin domain.
  sync_2ff #(
    .W (1)
  ) u_lock_sync (
    .i_clk   (i_clkin),
    .i_reset (i_reset),
    .i_d     (i_pll_lock),
    .o_q     (w_lock_s)
  );

  // Next-state, timer, counters and output decode; restart overrides every event.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_retry_nxt = r_retry_cnt;
    w_loss_nxt  = r_loss_cnt;

    if (i_restart) begin
      w_state_nxt = PLL_RST;
      w_timer_nxt = '0;
      w_retry_nxt = '0;
    end else begin
      unique case (r_state)
        PLL_RST: begin
          if (r_timer == RST_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (w_lock_s[0]) begin
            w_state_nxt = STABLE;
            w_timer_nxt = '0;
          end else if (r_timer == TMO_LAST) begin
            w_timer_nxt = '0;
            if (r_retry_cnt == RETRY_MAX) begin
              w_state_nxt = FAIL;
            end else begin
              w_state_nxt = PLL_RST;
              w_retry_nxt = r_retry_cnt + RW'(1);
            end
          end else begin
            w_timer_nxt = r_timer + CNT_W'(1);
          end
        end

        STABLE: begin
          // A dropout restarts the lock wait without consuming a retry.
          if (!w_lock_s[0]) begin
            w_state_nxt = WAIT_LOCK;
            w_timer_nxt = '0;
          end else if (r_timer == STABLE_LAST) begin
            w_state_nxt = RUN;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + CNT_W'(1);
          end
        end

        RUN: begin
          w_timer_nxt = '0;
          if (!w_lock_s[0]) begin
            w_state_nxt = PLL_RST;
            if (r_loss_cnt != LOSS_SAT) begin
              w_loss_nxt = r_loss_cnt + LOSS_W'(1);
            end
          end
        end

        FAIL: begin
          w_timer_nxt = '0;
        end

        default: begin
          w_state_nxt = PLL_RST;
          w_timer_nxt = '0;
        end
      endcase
    end

    w_ctl_nxt = ctl_for_state(w_state_nxt);
  end

  // State, counters and registered outputs; synchronous reset wins over restart.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_state     <= PLL_RST;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
      r_ctl       <= ctl_for_state(PLL_RST);
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_loss_cnt  <= w_loss_nxt;
      r_ctl       <= w_ctl_nxt;
    end
  end

  assign o_pll_reset = r_ctl.pll_reset;
  assign o_pix_rst   = r_ctl.pix_rst;
  assign o_locked_ok = r_ctl.locked_ok;
  assign o_fail      = r_ctl.fail;
  assign o_retry_cnt = r_retry_cnt;
  assign o_loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Self-checking bench for hdmi_pll_supervisor with short test timing.
module tb_hdmi_pll_supervisor;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 20;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned MAX_RETRY     = 2;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned RW            = $clog2(MAX_RETRY + 1);
  localparam int unsigned NOM_ROWS      = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          lock;
  logic          restart;
  logic          o_pll_reset;
  logic          o_pix_rst;
  logic          o_locked_ok;
  logic          o_fail;
  logic [RW-1:0] o_retry_cnt;
  logic [7:0]    o_loss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Expected output word: {pll_reset, pix_rst, locked_ok, fail, retry_cnt[1:0], loss_cnt[7:0]}.
  typedef struct {
    string       name;
    logic [13:0] exp;
  } exp_t;

  typedef struct {
    logic        lock;
    logic        restart;
    logic [13:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vtab[NOM_ROWS];

  always #5 clk = ~clk;

  hdmi_pll_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY),
    .CNT_W         (CNT_W)
  ) dut (
    .i_clkin     (clk),
    .i_reset     (rst),
    .i_pll_lock  (lock),
    .i_restart   (restart),
    .o_pll_reset (o_pll_reset),
    .o_pix_rst   (o_pix_rst),
    .o_locked_ok (o_locked_ok),
    .o_fail      (o_fail),
    .o_retry_cnt (o_retry_cnt),
    .o_loss_cnt  (o_loss_cnt)
  );

  function automatic logic [13:0] ov(input logic pr, input logic pix, input logic lok,
                                     input logic fl, input logic [1:0] rc, input logic [7:0] lc);
    return {pr, pix, lok, fl, rc, lc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [13:0] e);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t        x;
    logic [13:0] got;
    got = {o_pll_reset, o_pix_rst, o_locked_ok, o_fail, 2'(o_retry_cnt), o_loss_cnt};
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got=%h required=an expectation", got);
    end else begin
      x = sb.pop_front();
      if (got !== x.exp) begin
        n_errors++;
        $display("FAIL %s @%0t: got pr/pix/lok/fail/retry/loss=%b/%b/%b/%b/%0d/%0d required=%b/%b/%b/%b/%0d/%0d",
                 x.name, $time, got[13], got[12], got[11], got[10], got[9:8], got[7:0],
                 x.exp[13], x.exp[12], x.exp[11], x.exp[10], x.exp[9:8], x.exp[7:0]);
      end
    end
  endtask

  task automatic step_chk(input string nm, input logic [13:0] e);
    push_exp(nm, e);
    tick();
    check_out();
  endtask

  initial begin
    logic [7:0] lexp;

    // Nominal bring-up: lock rises 3 cycles after pll_reset falls, RUN after 8 STABLE cycles.
    for (int i = 0; i < int'(NOM_ROWS); i++) begin
      vtab[i].restart = 1'b0;
      vtab[i].lock    = (i >= 6);
      if (i < 3)       vtab[i].exp = ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      else if (i < 16) vtab[i].exp = ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      else             vtab[i].exp = ov(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    end

    rst     = 1'b1;
    lock    = 1'b0;
    restart = 1'b0;
    repeat (3) tick();
    step_chk("reset_state", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));
    rst = 1'b0;

    for (int i = 0; i < int'(NOM_ROWS); i++) begin
      lock    = vtab[i].lock;
      restart = vtab[i].restart;
      push_exp($sformatf("nominal_row%0d", i), vtab[i].exp);
      tick();
      check_out();
    end

    // Lock loss in RUN: visible two edges after the sampling edge, then a fresh 4-cycle pll_reset.
    lock = 1'b0;
    step_chk("loss_n0", ov(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0));
    step_chk("loss_n1", ov(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0));
    step_chk("loss_n2", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    repeat (3) step_chk("loss_pllrst", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    step_chk("loss_waitlock", ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));

    // Lock never asserts: 20-cycle waits, 4-cycle pulses, retries 1,2, then FAIL.
    for (int a = 0; a <= int'(MAX_RETRY); a++) begin
      repeat (LOCK_TIMEOUT - 1) step_chk($sformatf("wait_a%0d", a), ov(1'b0, 1'b1, 1'b0, 1'b0, 2'(a), 8'd1));
      if (a < int'(MAX_RETRY)) begin
        repeat (RST_CYCLES) step_chk($sformatf("retry_pulse_a%0d", a), ov(1'b1, 1'b1, 1'b0, 1'b0, 2'(a + 1), 8'd1));
        step_chk($sformatf("retry_wait_a%0d", a), ov(1'b0, 1'b1, 1'b0, 1'b0, 2'(a + 1), 8'd1));
      end
    end
    step_chk("fail_enter", ov(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1));
    repeat (30) step_chk("fail_hold", ov(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1));

    // Restart out of FAIL.
    restart = 1'b1;
    lock    = 1'b1;
    step_chk("restart_fail", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    restart = 1'b0;
    repeat (3) step_chk("rs_pllrst", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    repeat (9) step_chk("rs_prerun", ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));

    // Restart on the exact STABLE->RUN edge wins.
    restart = 1'b1;
    step_chk("restart_vs_run", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    restart = 1'b0;

    // Lock glitch in STABLE: back to WAIT_LOCK, RUN only after 8 fresh cycles.
    repeat (3) step_chk("gl_pllrst", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    repeat (5) step_chk("gl_pre", ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    lock = 1'b0;
    step_chk("gl_drop", ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    lock = 1'b1;
    repeat (10) step_chk("gl_requal", ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1));
    step_chk("gl_run", ov(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1));

    // Repeated RUN lock losses: loss_cnt saturates at 255.
    for (int k = 0; k < 259; k++) begin
      lexp = (k + 2 > 255) ? 8'd255 : 8'(k + 2);
      lock = 1'b0;
      tick();
      lock = 1'b1;
      tick();
      step_chk($sformatf("sat_loss_k%0d", k), ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, lexp));
      repeat (12) tick();
      step_chk($sformatf("sat_run_k%0d", k), ov(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, lexp));
    end

    // Reset together with restart: reset values, loss_cnt cleared.
    rst     = 1'b1;
    restart = 1'b1;
    step_chk("reset_prio", ov(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0));
    rst     = 1'b0;
    restart = 1'b0;

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: got=%0d entries required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
